// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one partial product per clock, product valid NPP edges after accept.
// in_ready only in IDLE; a finished product is held in DONE until out_ready, so the next accept waits for it.
module booth_seq_mul #(
  parameter int WIDTH  = 11,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);
  localparam int NPP = (WIDTH + 2) / 2;
  localparam int EW  = WIDTH + 2;
  localparam int AW  = 2 * WIDTH + 2;
  localparam int CW  = $clog2(NPP + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] a_q, a_d;
  // Bit 0 is the implicit zero below the multiplier LSB, so triplet k sits at [2k+2:2k].
  logic [EW:0]   b_q, b_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic          ext_a, ext_b;
  logic [EW:0]   b_sh;
  logic [2:0]    trip;
  logic [AW-1:0] a_wide, pp, pp_sh;

  always_comb begin
    ext_a  = (SIGNED != 0) && a[WIDTH-1];
    ext_b  = (SIGNED != 0) && b[WIDTH-1];
    b_sh   = b_q >> {cnt_q, 1'b0};
    trip   = b_sh[2:0];
    a_wide = {{WIDTH{a_q[EW-1]}}, a_q};
    unique case (trip)
      3'b001, 3'b010: pp = a_wide;
      3'b011:         pp = a_wide << 1;
      3'b100:         pp = -(a_wide << 1);
      3'b101, 3'b110: pp = -a_wide;
      default:        pp = '0;
    endcase
    pp_sh = pp << {cnt_q, 1'b0};

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {{2{ext_a}}, a};
          b_d     = {{2{ext_b}}, b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + pp_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NPP - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == CALC) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = acc_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul: directed latency/signed/backpressure/reset cases plus
// randomized traffic on eight width/mode combinations against an arithmetic reference.
module tb_booth_seq_mul;
  localparam int NRND = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rnd_en;
  int   n_pass = 0;
  int   n_tot  = 0;
  int   rnd_sent[8];
  int   rnd_recv[8];

  // Reference product: operands interpreted per mode, multiplied exactly, truncated to 2w bits.
  function automatic logic [31:0] model(input int w, input int s, input logic [31:0] x, input logic [31:0] y);
    longint xs, ys, m, p;
    m  = (longint'(1) << w) - 1;
    xs = longint'(x) & m;
    ys = longint'(y) & m;
    if (s != 0 && x[w-1]) xs = xs - (longint'(1) << w);
    if (s != 0 && y[w-1]) ys = ys - (longint'(1) << w);
    p = xs * ys;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Directed unit: WIDTH=11 unsigned.
  logic        u_iv, u_ir, u_ov, u_ordy, u_busy;
  logic [10:0] u_a, u_b;
  logic [21:0] u_out;
  booth_seq_mul #(.WIDTH(11), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(u_iv), .in_ready(u_ir), .a(u_a), .b(u_b),
    .out_valid(u_ov), .out_ready(u_ordy), .out(u_out), .busy(u_busy)
  );

  // Directed unit: WIDTH=8 signed.
  logic        s_iv, s_ir, s_ov, s_ordy, s_busy;
  logic [7:0]  s_a, s_b;
  logic [15:0] s_out;
  booth_seq_mul #(.WIDTH(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .a(s_a), .b(s_b),
    .out_valid(s_ov), .out_ready(s_ordy), .out(s_out), .busy(s_busy)
  );

  // Random traffic units: widths 4/8/11/16, unsigned (0..3) and signed (4..7).
  for (genvar gi = 0; gi < 8; gi++) begin : g_rnd
    localparam int W = (gi % 4 == 0) ? 4 : (gi % 4 == 1) ? 8 : (gi % 4 == 2) ? 11 : 16;
    localparam int S = gi / 4;
    logic           r_iv, r_ir, r_ov, r_ordy, r_busy;
    logic [W-1:0]   r_a, r_b;
    logic [2*W-1:0] r_out;
    logic [31:0]    expq[$];
    logic [31:0]    got;

    booth_seq_mul #(.WIDTH(W), .SIGNED(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(r_iv), .in_ready(r_ir), .a(r_a), .b(r_b),
      .out_valid(r_ov), .out_ready(r_ordy), .out(r_out), .busy(r_busy)
    );

    initial begin
      r_iv = 1'b0; r_a = '0; r_b = '0; rnd_sent[gi] = 0;
      wait (rnd_en);
      while (rnd_sent[gi] < NRND) begin
        @(negedge clk);
        r_iv = ($urandom_range(0, 3) != 0);
        r_a  = W'($urandom);
        r_b  = W'($urandom);
        if (r_iv && r_ir) begin
          expq.push_back(model(W, S, 32'(r_a), 32'(r_b)));
          rnd_sent[gi]++;
        end
      end
      @(negedge clk);
      r_iv = 1'b0;
    end

    initial begin
      r_ordy = 1'b0; rnd_recv[gi] = 0;
      wait (rnd_en);
      forever begin
        @(negedge clk);
        r_ordy = ($urandom_range(0, 2) != 0);
        if (r_ov && r_ordy) begin
          got = 32'(r_out);
          n_tot++;
          if (expq.size() == 0) begin
            $display("FAIL rnd%0d_extra: got %h with no operand pair pending", gi, got);
          end else begin
            if (got !== expq[0])
              $display("FAIL rnd%0d_product: got %h expected %h", gi, got, expq[0]);
            else
              n_pass++;
            void'(expq.pop_front());
          end
          rnd_recv[gi]++;
        end
      end
    end
  end

  task automatic start_u(input logic [10:0] x, input logic [10:0] y, output bit ok);
    int e;
    e = 0;
    while (!u_ir && e < 30) begin @(negedge clk); e++; end
    ok = u_ir;
    u_iv = 1'b1; u_a = x; u_b = y;
    @(negedge clk);
    u_iv = 1'b0;
    u_a = 11'($urandom);
    u_b = 11'($urandom);
  endtask

  task automatic wait_u_ov(output int edges);
    edges = 0;
    while (!u_ov && edges < 30) begin @(negedge clk); edges++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; u_iv = 1'b1; u_a = 11'd5; u_b = 11'd7; s_iv = 1'b1;
    repeat (3) @(negedge clk);
    n_tot++; if (u_ir !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", u_ir); else n_pass++;
    n_tot++; if (u_ov !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", u_ov); else n_pass++;
    n_tot++; if (u_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", u_busy); else n_pass++;
    n_tot++; if (u_out !== 22'd0) $display("FAIL reset_out: got %0d expected 0", u_out); else n_pass++;
    n_tot++; if (s_ir !== 1'b1 || s_out !== 16'd0) $display("FAIL reset_signed_unit: ready %b out %h expected 1/0", s_ir, s_out); else n_pass++;
    rst = 1'b0; u_iv = 1'b0; s_iv = 1'b0;
    @(negedge clk);
    n_tot++; if (u_ir !== 1'b1 || u_busy !== 1'b0) $display("FAIL reset_release_idle: ready %b busy %b expected 1/0", u_ir, u_busy); else n_pass++;
  endtask

  task automatic test_latency();
    bit ok;
    int e;
    u_ordy = 1'b1;
    start_u(11'd2047, 11'd2047, ok);
    n_tot++; if (!ok || u_busy !== 1'b1) $display("FAIL latency_accept: ready %b busy %b expected 1/1", ok, u_busy); else n_pass++;
    wait_u_ov(e);
    n_tot++; if (e != 6) $display("FAIL latency_edges: got %0d expected 6", e); else n_pass++;
    n_tot++; if (u_out !== 22'd4190209) $display("FAIL latency_product: got %0d expected 4190209", u_out); else n_pass++;
    @(negedge clk);
    n_tot++; if (u_ir !== 1'b1 || u_ov !== 1'b0) $display("FAIL latency_return_idle: ready %b valid %b expected 1/0", u_ir, u_ov); else n_pass++;
  endtask

  task automatic test_signed();
    logic [7:0]  ta[4];
    logic [7:0]  tb[4];
    logic [15:0] te[4];
    int e;
    ta = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    tb = '{8'h80, 8'h01, 8'hB3, 8'h80};
    te = '{16'h4000, 16'hFFFF, 16'h0000, 16'hC080};
    s_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = 0;
      while (!s_ir && e < 30) begin @(negedge clk); e++; end
      s_iv = 1'b1; s_a = ta[i]; s_b = tb[i];
      @(negedge clk);
      s_iv = 1'b0; s_a = 8'($urandom); s_b = 8'($urandom);
      e = 0;
      while (!s_ov && e < 30) begin @(negedge clk); e++; end
      n_tot++; if (e != 5) $display("FAIL signed%0d_edges: got %0d expected 5", i, e); else n_pass++;
      n_tot++; if (s_out !== te[i]) $display("FAIL signed%0d_product: got %h expected %h", i, s_out, te[i]); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int e;
    logic [10:0] x, y;
    logic [21:0] held;
    u_ordy = 1'b0;
    x = 11'($urandom); y = 11'($urandom);
    start_u(x, y, ok);
    wait_u_ov(e);
    n_tot++; if (!ok || e != 6) $display("FAIL bp_edges: got %0d expected 6", e); else n_pass++;
    n_tot++; if (u_out !== 22'(model(11, 0, 32'(x), 32'(y)))) $display("FAIL bp_product: got %0d expected %0d", u_out, model(11, 0, 32'(x), 32'(y))); else n_pass++;
    held = u_out;
    u_iv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      u_a = 11'($urandom); u_b = 11'($urandom);
      @(negedge clk);
      n_tot++;
      if (u_out !== held || u_ir !== 1'b0 || u_ov !== 1'b1)
        $display("FAIL bp_hold%0d: out %0d ready %b valid %b expected %0d/0/1", i, u_out, u_ir, u_ov, held);
      else n_pass++;
    end
    u_iv = 1'b0; u_ordy = 1'b1;
    @(negedge clk);
    n_tot++; if (u_ir !== 1'b1 || u_ov !== 1'b0 || u_busy !== 1'b0) $display("FAIL bp_release: ready %b valid %b busy %b expected 1/0/0", u_ir, u_ov, u_busy); else n_pass++;
  endtask

  task automatic test_reset_midop();
    bit ok;
    bit seen;
    u_ordy = 1'b1;
    start_u(11'($urandom), 11'($urandom), ok);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tot++; if (!ok || u_ir !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", u_ir); else n_pass++;
    n_tot++; if (u_ov !== 1'b0 || u_busy !== 1'b0) $display("FAIL midrst_valid_busy: valid %b busy %b expected 0/0", u_ov, u_busy); else n_pass++;
    n_tot++; if (u_out !== 22'd0) $display("FAIL midrst_out: got %0d expected 0", u_out); else n_pass++;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (u_ov) seen = 1'b1; end
    n_tot++; if (seen) $display("FAIL midrst_no_product: got out_valid pulse expected none"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit all_done;
    rnd_en = 1'b1;
    cyc = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      all_done = 1'b1;
      for (int i = 0; i < 8; i++)
        if (rnd_recv[i] < NRND) all_done = 1'b0;
    end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_tot++; if (rnd_sent[i] != NRND) $display("FAIL rnd%0d_sent: got %0d expected %0d", i, rnd_sent[i], NRND); else n_pass++;
      n_tot++; if (rnd_recv[i] != NRND) $display("FAIL rnd%0d_received: got %0d expected %0d", i, rnd_recv[i], NRND); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; rnd_en = 1'b0;
    u_iv = 1'b0; u_a = '0; u_b = '0; u_ordy = 1'b0;
    s_iv = 1'b0; s_a = '0; s_b = '0; s_ordy = 1'b0;
    test_reset();
    test_latency();
    test_signed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
